serial_adder_ctrl: RTL and testbench

//   Bit-serial N-bit adder built around a single full-adder cell (fa_somma / fa_riporto pair).
//   The controller loads two operands on a start request and feeds them LSB-first into the cell,
//   one bit per clock. It holds the running carry in a flip-flop and collects sum bits into a

---
 rtl/serial_adder_ctrl_if.sv | 34 +++
 rtl/serial_adder_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
//   Request/result bundle between a requester and the bit-serial adder
//   controller.
//   master (requester): drives start, a, b, cin; observes busy, done, sum, cout
//   slave  (adder)    : observes start, a, b, cin; drives busy, done, sum, cout
//   start  request, captured with a, b, cin when the adder is IDLE or DONE
//   a, b   N-bit unsigned operands
//   cin    carry-in
//   busy   high while bits are being added
//   done   one-cycle pulse, sum/cout valid
//   sum    N-bit result
//   cout   final carry-out
interface serial_adder_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial N-bit adder around one full-adder cell (fa_somma/fa_riporto).
//   An accepted start captures a, b, cin; the operands are then shifted
//   LSB-first through the cell, one bit per clock, with the running carry
//   held in a flip-flop and sum bits collected in a shift register.
//   {cout, sum} = a + b + cin after N RUN cycles; done pulses for one cycle.
// Ports
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    serial_adder_ctrl_if.slave: start/a/b/cin in, busy/done/sum/cout out
// Parameters
//   N      operand/result width, N >= 1
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_adder_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0]     opa, opa_nxt;
    logic [N-1:0]     opb, opb_nxt;
    logic [N-1:0]     sum_r, sum_nxt;
    logic             carry, carry_nxt;
    logic             cout_r, cout_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic fa_somma;
    logic fa_riporto;
    logic load;
    logic step;
    logic last;

    // Shared full-adder cell: always looks at the current LSBs and carry.
    always_comb begin
        fa_somma   = carry ^ opa[0] ^ opb[0];
        fa_riporto = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath next values. The sum register is built as a right shift with
    // the new bit forced into the MSB, which also works for N == 1 where a
    // {s, sum[N-1:1]} concatenation would need an empty slice.
    always_comb begin
        opa_nxt   = opa;
        opb_nxt   = opb;
        sum_nxt   = sum_r;
        carry_nxt = carry;
        cout_nxt  = cout_r;
        cnt_nxt   = cnt;
        if (load) begin
            opa_nxt   = bus.a;
            opb_nxt   = bus.b;
            carry_nxt = bus.cin;
            sum_nxt   = '0;
            cnt_nxt   = '0;
        end else if (step) begin
            opa_nxt          = opa >> 1;
            opb_nxt          = opb >> 1;
            sum_nxt          = sum_r >> 1;
            sum_nxt[N-1]     = fa_somma;
            carry_nxt        = fa_riporto;
            cnt_nxt          = cnt + CNT_W'(1);
            if (last) begin
                cout_nxt = fa_riporto;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            opa    <= '0;
            opb    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            opa    <= opa_nxt;
            opb    <= opb_nxt;
            sum_r  <= sum_nxt;
            carry  <= carry_nxt;
            cout_r <= cout_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Outputs come straight from registers (busy/done decode the state reg).
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Directed and randomised checks of serial_adder_ctrl at N = 1, 8 and 13.
module tb_serial_adder_ctrl;

    logic clock;
    logic reset;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    serial_adder_ctrl_if #(.N(1))  bus1 ();
    serial_adder_ctrl_if #(.N(8))  bus8 ();
    serial_adder_ctrl_if #(.N(13)) bus13 ();

    serial_adder_ctrl #(.N(1))  dut1  (.clock(clock), .reset(reset), .bus(bus1));
    serial_adder_ctrl #(.N(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));
    serial_adder_ctrl #(.N(13)) dut13 (.clock(clock), .reset(reset), .bus(bus13));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output view of the instance currently under test
    int unsigned cur_w = 8;
    logic        mdone;
    logic        mbusy;
    logic [63:0] mres;

    always_comb begin
        mdone = 1'b0;
        mbusy = 1'b0;
        mres  = '0;
        case (cur_w)
            1: begin
                mdone = bus1.done;
                mbusy = bus1.busy;
                mres  = 64'({bus1.cout, bus1.sum});
            end
            8: begin
                mdone = bus8.done;
                mbusy = bus8.busy;
                mres  = 64'({bus8.cout, bus8.sum});
            end
            13: begin
                mdone = bus13.done;
                mbusy = bus13.busy;
                mres  = 64'({bus13.cout, bus13.sum});
            end
            default: begin
                mdone = 1'b0;
            end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int unsigned w, input logic st, input logic [63:0] av,
                          input logic [63:0] bv, input logic cv);
        case (w)
            1: begin
                bus1.start = st; bus1.a = av[0:0]; bus1.b = bv[0:0]; bus1.cin = cv;
            end
            8: begin
                bus8.start = st; bus8.a = av[7:0]; bus8.b = bv[7:0]; bus8.cin = cv;
            end
            13: begin
                bus13.start = st; bus13.a = av[12:0]; bus13.b = bv[12:0]; bus13.cin = cv;
            end
            default: begin
                bus8.start = 1'b0;
            end
        endcase
    endtask

    // Called at the first falling edge after an accepted start (lat = 1 there).
    // With poke set, start is pulsed with junk operands while RUN is active.
    task automatic wait_done(input int unsigned w, input bit poke, output logic [63:0] res,
                             output int unsigned lat, output int unsigned nbusy);
        res   = '0;
        nbusy = 0;
        for (lat = 1; lat <= 64; lat++) begin
            if (poke) set_in(w, (lat == 2 || lat == 4), '1, '1, 1'b1);
            if (mdone) begin
                res = mres;
                break;
            end
            if (mbusy) nbusy++;
            @(negedge clock);
        end
        if (poke) set_in(w, 1'b0, '0, '0, 1'b0);
    endtask

    // Called on a falling edge; returns on the falling edge in the DONE cycle.
    task automatic run_op(input int unsigned w, input logic [63:0] av, input logic [63:0] bv,
                          input logic cv, input bit poke, output logic [63:0] res,
                          output int unsigned lat, output int unsigned nbusy);
        cur_w = w;
        set_in(w, 1'b1, av, bv, cv);
        @(posedge clock);
        @(negedge clock);
        set_in(w, 1'b0, av, bv, cv);
        wait_done(w, poke, res, lat, nbusy);
    endtask

    logic [63:0] res;
    logic [63:0] av, bv, exp, msk;
    logic        cv;
    int unsigned lat, nb, ndone;
    int unsigned widths [3] = '{1, 8, 13};

    initial begin
        reset = 1'b1;
        set_in(1, 1'b0, '0, '0, 1'b0);
        set_in(8, 1'b0, '0, '0, 1'b0);
        set_in(13, 1'b0, '0, '0, 1'b0);

        // 1: reset then idle
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset_state", 64'({bus8.busy, bus8.done, bus8.cout, bus8.sum}), 64'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle", 64'({bus8.busy, bus8.done, bus8.cout, bus8.sum}), 64'h0);
        end

        // 2: basic add
        run_op(8, 64'h3A, 64'h25, 1'b0, 1'b0, res, lat, nb);
        check("t2_sum", res, 64'h05F);
        check("t2_lat", 64'(lat), 64'd9);
        check("t2_busy", 64'(nb), 64'd8);

        // 3: carry chain (second op starts straight from DONE)
        run_op(8, 64'hFF, 64'h00, 1'b1, 1'b0, res, lat, nb);
        check("t3_ff_00_1", res, 64'h100);
        run_op(8, 64'hFF, 64'hFF, 1'b1, 1'b0, res, lat, nb);
        check("t3_ff_ff_1", res, 64'h1FF);
        check("t3_lat", 64'(lat), 64'd9);

        @(negedge clock);
        @(negedge clock);
        check("idle_hold", 64'({bus8.busy, bus8.done, bus8.cout, bus8.sum}), 64'h1FF);

        // 4: back-to-back, start held through DONE, pulses during RUN ignored
        run_op(8, 64'h10, 64'h20, 1'b0, 1'b0, res, lat, nb);
        check("t4_first", res, 64'h030);
        run_op(8, 64'h01, 64'h01, 1'b0, 1'b1, res, lat, nb);
        check("t4_second", res, 64'h002);
        check("t4_lat", 64'(lat), 64'd9);
        check("t4_busy", 64'(nb), 64'd8);

        // 5: abort mid-RUN; cout is 1 beforehand so the reset clear is visible
        run_op(8, 64'h80, 64'h80, 1'b0, 1'b0, res, lat, nb);
        check("t5_pre", res, 64'h100);
        set_in(8, 1'b1, 64'hAA, 64'h55, 1'b0);
        @(posedge clock);
        @(negedge clock);
        set_in(8, 1'b0, 64'hAA, 64'h55, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t5_abort", 64'({bus8.busy, bus8.done, bus8.cout, bus8.sum}), 64'h0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus8.done) ndone++;
        end
        check("t5_nodone", 64'(ndone), 64'd0);

        // reset and start on the same edge: reset wins
        reset = 1'b1;
        set_in(8, 1'b1, 64'h01, 64'h01, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        set_in(8, 1'b0, 64'h01, 64'h01, 1'b0);
        check("rst_vs_start", 64'({bus8.busy, bus8.done}), 64'h0);
        @(negedge clock);
        check("rst_vs_start2", 64'({bus8.busy, bus8.done}), 64'h0);

        // 6: randomised against a + b + cin
        foreach (widths[k]) begin
            msk = (64'd1 << widths[k]) - 64'd1;
            for (int i = 0; i < 1000; i++) begin
                av  = 64'($urandom) & msk;
                bv  = 64'($urandom) & msk;
                cv  = 1'($urandom_range(1));
                exp = av + bv + 64'(cv);
                if ($urandom_range(3) == 0) @(negedge clock);
                run_op(widths[k], av, bv, cv, 1'b0, res, lat, nb);
                check($sformatf("rand_w%0d_sum", widths[k]), res, exp);
                check($sformatf("rand_w%0d_lat", widths[k]), 64'(lat), 64'(widths[k] + 1));
                check($sformatf("rand_w%0d_busy", widths[k]), 64'(nb), 64'(widths[k]));
            end
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
